sync_fifo: RTL
==============

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 8, entry count; power of two, >=2.
REQ-003 Parameter AF_LEVEL, default DEPTH-2, occupancy at or above which almost_full asserts (1..DEPTH).
REQ-004 Port clock: input, 1 bit, single clock; all state changes on its rising edge.
REQ-005 Port reset: input, 1 bit, asynchronous, active-high reset.
REQ-006 Port push: input, 1 bit, write request for D this cycle.
REQ-007 Port pop: input, 1 bit, read request; head entry removed this cycle.
REQ-008 Port D: input, WIDTH bits, write data.
REQ-009 Port Q: output, WIDTH bits, head entry (show-ahead).
REQ-010 Port full: output, 1 bit, occupancy == DEPTH.
REQ-011 Port empty: output, 1 bit, occupancy == 0.
REQ-012 Port almost_full: output, 1 bit, occupancy >= AF_LEVEL.
REQ-013 Port count: output, $clog2(DEPTH)+1 bits, current occupancy 0..DEPTH.

Function
REQ-014 Accepted push (push && (!full || pop)) SHALL write D at write pointer on the edge, then advance write pointer modulo DEPTH.
REQ-015 Accepted pop (pop && !empty) SHALL advance read pointer modulo DEPTH on the edge.
REQ-016 Push while full without pop SHALL be ignored: no write, no pointer or count change.
REQ-017 Pop while empty SHALL be ignored; push && pop while empty SHALL perform the push only (count 0 -> 1).
REQ-018 push && pop while full SHALL perform both; count stays DEPTH, full stays 1.
REQ-019 push && pop with 0 < count < DEPTH SHALL perform both; count unchanged.
REQ-020 count SHALL increment on accepted push alone, decrement on accepted pop alone; never exceed DEPTH nor go below 0.
REQ-021 full, empty, almost_full SHALL be registered or derived only from registered count; no combinational path from push/pop.
REQ-022 Q SHALL equal the entry at read pointer when !empty, and 0 when empty.
REQ-023 Latency: word pushed into an empty FIFO at edge N SHALL appear on Q, with empty=0, immediately after edge N.
REQ-024 Pointers SHALL wrap from DEPTH-1 to 0 with no data loss; FIFO order preserved across wrap.

Reset
REQ-025 reset=1 SHALL immediately clear both pointers and count; empty=1, full=0, almost_full=0, Q=0, independent of clock.
REQ-026 Reset mid-operation SHALL discard all contents; storage array itself SHALL NOT be reset.
REQ-027 First accepted push SHALL be possible on the first rising edge after reset deasserts.

Configuration
REQ-028 Macro SYNC_FIFO_ERR_FLAGS_EN, when defined, SHALL add outputs overflow and underflow (1 bit each) and input clear_err (1 bit).
REQ-029 With macro: overflow sets on an ignored push (REQ-016), underflow sets on an ignored pop (REQ-017 first clause); both sticky until clear_err=1 at an edge or reset; set wins over clear in the same cycle.
REQ-030 Without macro: those ports and their logic SHALL not exist; all other behaviour identical.

Structure
REQ-031 Package sync_fifo_pkg SHALL hold default constants (FIFO_DEF_WIDTH=8, FIFO_DEF_DEPTH=8) and the pointer-width function used for count and pointers.
REQ-032 Storage SHALL be a sub-module sync_fifo_mem: registered write with write enable, combinational read by address, no reset.
REQ-033 Control (pointers, count, flags, error flags) SHALL reside in sync_fifo.

Verification (WIDTH=8, DEPTH=4, AF_LEVEL=3)
REQ-034 Reset, push 0x11,0x22,0x33,0x44 -> count 1,2,3,4; almost_full at count 3; full after 4th edge; Q=0x11 throughout.
REQ-035 From full, push 0x55 without pop -> contents unchanged, count=4; overflow=1 with macro.
REQ-036 From full, push 0x55 with pop -> Q=0x22, count=4, full=1; then 4 pops yield 0x22,0x33,0x44,0x55 and empty=1, Q=0.
REQ-037 From empty, push 0xA5 with pop -> count=1, Q=0xA5; pop on empty -> count 0 unchanged, underflow=1 with macro; clear_err -> flags 0.
REQ-038 Ten push/pop pairs with single-entry occupancy -> pointers wrap twice, each popped value equals value pushed prior cycle.
REQ-039 Assert reset between clock edges with count=3 -> empty=1, count=0, Q=0 before next edge; push 0x77 next edge -> Q=0x77.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared defaults and pointer-width helper for sync_fifo
package sync_fifo_pkg;

    localparam int FIFO_DEF_WIDTH = 8;
    localparam int FIFO_DEF_DEPTH = 8;

    // Address width of a power-of-two deep array; count uses one extra bit to reach DEPTH.
    function automatic int fifo_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// rtl/sync_fifo_mem.sv - FIFO storage array, registered write, combinational read, no reset
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_DEF_WIDTH,
    parameter int DEPTH = FIFO_DEF_DEPTH
) (
    input  logic                          clock,
    input  logic                          wr_en,
    input  logic [fifo_ptr_w(DEPTH)-1:0]  wr_addr,
    input  logic [WIDTH-1:0]              wr_data,
    input  logic [fifo_ptr_w(DEPTH)-1:0]  rd_addr,
    output logic [WIDTH-1:0]              rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO; SYNC_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH    = FIFO_DEF_WIDTH,
    parameter int DEPTH    = FIFO_DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        push,
    input  logic                        pop,
    input  logic [WIDTH-1:0]            D,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    input  logic                        clear_err,
    output logic                        overflow,
    output logic                        underflow,
`endif
    output logic [WIDTH-1:0]            Q,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic [fifo_ptr_w(DEPTH):0]  count
);

    localparam int AW = fifo_ptr_w(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem_rdata;
    logic             do_push;
    logic             do_pop;

    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Status flags decode the registered count only, so push/pop never reach them combinationally.
    assign full        = (count == FULL_CNT);
    assign empty       = (count == '0);
    assign almost_full = (count >= AF_CNT);
    assign Q           = empty ? '0 : mem_rdata;

    sync_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clock   (clock),
        .wr_en   (do_push),
        .wr_addr (wr_ptr),
        .wr_data (D),
        .rd_addr (rd_ptr),
        .rd_data (mem_rdata)
    );

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic ovf_event;
    logic unf_event;

    // push+pop on empty is a plain push, so only a lone pop counts as underflow.
    assign ovf_event = push && full && !pop;
    assign unf_event = pop && empty && !push;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_event) begin
                overflow <= 1'b1;
            end else if (clear_err) begin
                overflow <= 1'b0;
            end
            if (unf_event) begin
                underflow <= 1'b1;
            end else if (clear_err) begin
                underflow <= 1'b0;
            end
        end
    end
`endif

endmodule
